// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Sequencer for the stopwatch up/down counter. It conditions the start/stop,
// clear and lap buttons, owns the 1 Hz prescaler and drives the counter
// datapath through a 1-cycle enable, a direction bit and a synchronous load.
// Everything runs in the clk_5MHz domain.
//
// Build option:
//   STOPWATCH_DEBOUNCE_EN - when defined, every synchronised button passes a
//   counter-based debouncer. The debouncer needs DEB_CYCLES consecutive equal
//   samples before it accepts a new level. Press latency becomes
//   3 + DEB_CYCLES cycles. When undefined, a press is every clean rising edge
//   after the 2-flop synchroniser, with a latency of 3 cycles.
//
// Strobe semantics:
//   cnt_en_o, cnt_load_o and tick_1hz_o are single-cycle pulses. There is no
//   back-pressure: the counter must act on every cycle a strobe is high.
//   load_val_o carries meaning only while cnt_load_o is high, and reads 0
//   otherwise. cnt_load_o and cnt_en_o are never high together.
//
// state_o exposes the FSM state directly:
//   IDLE = 00, RUN = 01, PAUSE = 10, DONE = 11
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned COUNT_SIZE = 8,
  parameter int unsigned TICK_DIV   = 5_000_000
`ifdef STOPWATCH_DEBOUNCE_EN
  ,
  parameter int unsigned DEB_CYCLES = 50_000
`endif
) (
  input  logic                  clk_5MHz,
  input  logic                  reset,
  input  logic                  btn_ss_i,
  input  logic                  btn_clr_i,
  input  logic                  btn_lap_i,
  input  logic                  dir_dn_i,
  input  logic [COUNT_SIZE-1:0] preset_i,
  input  logic [COUNT_SIZE-1:0] count_i,
  output logic                  cnt_en_o,
  output logic                  cnt_up_dn_o,
  output logic                  cnt_load_o,
  output logic [COUNT_SIZE-1:0] load_val_o,
  output logic                  tick_1hz_o,
  output logic                  lap_freeze_o,
  output logic                  alarm_o,
  output logic [1:0]            state_o
);

  // Prescaler width is sized to hold TICK_DIV-1, with a floor of one bit.
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning. Bit 0 = start/stop, bit 1 = clear, bit 2 = lap.
  // The synchroniser and edge-reference flops reset to 1. A button still held
  // as reset releases therefore looks like an already-seen level rather than
  // a fresh rising edge, so it creates no press.
  // ---------------------------------------------------------------------------
  logic [2:0] btn_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] btn_level;
  logic [2:0] edge_ref_q;
  logic [2:0] press;

  assign btn_raw = {btn_lap_i, btn_clr_i, btn_ss_i};

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  // The debounce counter only has to reach DEB_CYCLES-1, with a floor of one bit.
  localparam int unsigned DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  logic [2:0]     deb_q;
  logic [DCW-1:0] deb_cnt_q [3];

  // Accept a new level only after DEB_CYCLES consecutive samples that differ
  // from the accepted one. Any sample that agrees with the accepted level
  // restarts the count, so short glitches are discarded.
  always_ff @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      deb_q <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign btn_level = deb_q;
`else
  assign btn_level = sync2_q;
`endif

  // Remember the previous conditioned level for rising-edge detection.
  always_ff @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      edge_ref_q <= 3'b111;
    end else begin
      edge_ref_q <= btn_level;
    end
  end

  assign press = btn_level & ~edge_ref_q;

  logic ss_p;
  logic clr_p;
  logic lap_p;

  assign ss_p  = press[0];
  assign clr_p = press[1];
  assign lap_p = press[2];

  // ---------------------------------------------------------------------------
  // Sequencer with registered outputs.
  // Within a single cycle, clear takes priority over start/stop, which takes
  // priority over lap.
  // ---------------------------------------------------------------------------
  state_t                state_q;
  logic [PW-1:0]         presc_q;
  logic                  cnt_en_q;
  logic                  cnt_up_dn_q;
  logic                  cnt_load_q;
  logic [COUNT_SIZE-1:0] load_val_q;
  logic                  tick_q;
  logic                  lap_freeze_q;
  logic                  alarm_q;

  // State, prescaler and every counter-control output, updated once per cycle.
  always_ff @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      cnt_en_q     <= 1'b0;
      cnt_up_dn_q  <= 1'b0;
      cnt_load_q   <= 1'b0;
      load_val_q   <= '0;
      tick_q       <= 1'b0;
      lap_freeze_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      // The pulse outputs fall back to 0 unless this cycle raises them.
      cnt_en_q   <= 1'b0;
      cnt_load_q <= 1'b0;
      tick_q     <= 1'b0;
      load_val_q <= '0;

      if (clr_p) begin
        // Clear from any state: load 0 and return to a clean IDLE.
        state_q      <= S_IDLE;
        cnt_load_q   <= 1'b1;
        load_val_q   <= '0;
        presc_q      <= '0;
        lap_freeze_q <= 1'b0;
        alarm_q      <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            presc_q <= '0;
            if (ss_p) begin
              // Lock the direction for the whole run and preload the counter.
              state_q     <= S_RUN;
              cnt_load_q  <= 1'b1;
              load_val_q  <= dir_dn_i ? preset_i : '0;
              cnt_up_dn_q <= ~dir_dn_i;
            end
          end

          S_RUN: begin
            if (ss_p) begin
              // Pause with the prescaler phase preserved.
              state_q <= S_PAUSE;
            end else begin
              if (lap_p) begin
                lap_freeze_q <= ~lap_freeze_q;
              end
              if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                tick_q  <= 1'b1;
                // A countdown that is already at zero stops here, so the
                // counter never underflows.
                if (!cnt_up_dn_q && (count_i == '0)) begin
                  state_q <= S_DONE;
                  alarm_q <= 1'b1;
                end else begin
                  cnt_en_q <= 1'b1;
                end
              end else begin
                presc_q <= presc_q + 1'b1;
              end
            end
          end

          S_PAUSE: begin
            // Prescaler frozen and lap ignored; only start/stop resumes.
            if (ss_p) begin
              state_q <= S_RUN;
            end
          end

          S_DONE: begin
            if (ss_p) begin
              state_q      <= S_IDLE;
              alarm_q      <= 1'b0;
              lap_freeze_q <= 1'b0;
              presc_q      <= '0;
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign cnt_en_o     = cnt_en_q;
  assign cnt_up_dn_o  = cnt_up_dn_q;
  assign cnt_load_o   = cnt_load_q;
  assign load_val_o   = load_val_q;
  assign tick_1hz_o   = tick_q;
  assign lap_freeze_o = lap_freeze_q;
  assign alarm_o      = alarm_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl in its default build (no debouncer), with
// TICK_DIV = 10.
//
// A bench-side counter plays the datapath and feeds count back to the DUT.
// The behavioural model works from elapsed run time and button events: a raw
// rise acts on the state on the third clock edge after it. The model pushes
// one expected output word per clock into exp_q, and a negedge process
// compares each word against the DUT. Directed steps add literal checks at
// hand-computed cycle offsets.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int CS = 8;
  localparam int TD = 10;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  logic          clk_5MHz = 1'b0;
  logic          reset;
  logic          btn_ss;
  logic          btn_clr;
  logic          btn_lap;
  logic          dir_dn;
  logic [CS-1:0] preset;
  logic [CS-1:0] count;
  logic          cnt_en;
  logic          cnt_up_dn;
  logic          cnt_load;
  logic [CS-1:0] load_val;
  logic          tick_1hz;
  logic          lap_freeze;
  logic          alarm;
  logic [1:0]    state;

  int n_vec  = 0;
  int n_fail = 0;

  stopwatch_ctrl #(
    .COUNT_SIZE(CS),
    .TICK_DIV  (TD)
  ) dut (
    .clk_5MHz    (clk_5MHz),
    .reset       (reset),
    .btn_ss_i    (btn_ss),
    .btn_clr_i   (btn_clr),
    .btn_lap_i   (btn_lap),
    .dir_dn_i    (dir_dn),
    .preset_i    (preset),
    .count_i     (count),
    .cnt_en_o    (cnt_en),
    .cnt_up_dn_o (cnt_up_dn),
    .cnt_load_o  (cnt_load),
    .load_val_o  (load_val),
    .tick_1hz_o  (tick_1hz),
    .lap_freeze_o(lap_freeze),
    .alarm_o     (alarm),
    .state_o     (state)
  );

  // ---------------- clock / reset ----------------
  always #100 clk_5MHz = ~clk_5MHz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counter datapath stand-in ----------------
  always @(posedge clk_5MHz or posedge reset) begin
    if (reset) count <= '0;
    else if (cnt_load) count <= load_val;
    else if (cnt_en) count <= cnt_up_dn ? count + 8'd1 : count - 8'd1;
  end

  // ---------------- behavioural model ----------------
  // Output word layout: {state[15:14], en[13], up_dn[12], load[11],
  // load_val[10:3], tick[2], lap[1], alarm[0]}.
  logic [15:0] exp_q[$];
  logic [1:0]  m_state;
  int          m_run;
  logic        m_updn;
  logic        m_lap;
  logic        m_alarm;
  // Raw button samples from the last three edges; index 0 is the newest.
  logic [2:0]  h_ss;
  logic [2:0]  h_clr;
  logic [2:0]  h_lap;

  always @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      m_state <= ST_IDLE;
      m_run   <= 0;
      m_updn  <= 1'b0;
      m_lap   <= 1'b0;
      m_alarm <= 1'b0;
      h_ss    <= 3'b111;
      h_clr   <= 3'b111;
      h_lap   <= 3'b111;
      exp_q.delete();
    end else begin
      logic [1:0]    st;
      int            run;
      logic          updn, lap, alm, en, ld, tk;
      logic [CS-1:0] lv;
      logic          p_ss, p_clr, p_lap;
      st = m_state; run = m_run; updn = m_updn; lap = m_lap; alm = m_alarm;
      en = 1'b0; ld = 1'b0; tk = 1'b0; lv = '0;
      // A press acts two edges after its rise was first sampled.
      p_ss  = h_ss[1]  & ~h_ss[2];
      p_clr = h_clr[1] & ~h_clr[2];
      p_lap = h_lap[1] & ~h_lap[2];
      if (p_clr) begin
        st = ST_IDLE; ld = 1'b1; lv = '0; run = 0; lap = 1'b0; alm = 1'b0;
      end else if (st == ST_IDLE) begin
        run = 0;
        if (p_ss) begin
          st = ST_RUN; ld = 1'b1; lv = dir_dn ? preset : '0; updn = ~dir_dn;
        end
      end else if (st == ST_RUN) begin
        if (p_ss) st = ST_PAUSE;
        else begin
          if (p_lap) lap = ~lap;
          // One tick per TD cycles of accumulated run time.
          if (run % TD == TD - 1) begin
            tk = 1'b1;
            if (!updn && count == 0) begin st = ST_DONE; alm = 1'b1; end
            else en = 1'b1;
          end
          run = run + 1;
        end
      end else if (st == ST_PAUSE) begin
        if (p_ss) st = ST_RUN;
      end else begin
        if (p_ss) begin st = ST_IDLE; alm = 1'b0; lap = 1'b0; run = 0; end
      end
      m_state <= st;
      m_run   <= run;
      m_updn  <= updn;
      m_lap   <= lap;
      m_alarm <= alm;
      h_ss    <= {h_ss[1:0], btn_ss};
      h_clr   <= {h_clr[1:0], btn_clr};
      h_lap   <= {h_lap[1:0], btn_lap};
      exp_q.push_back({st, en, updn, ld, lv, tk, lap, alm});
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_word();
    return {state, cnt_en, cnt_up_dn, cnt_load, load_val, tick_1hz, lap_freeze, alarm};
  endfunction

  always @(negedge clk_5MHz) begin
    logic [15:0] act, e;
    act = dut_word();
    if (reset) begin
      chk("reset_outputs", act, 16'h0000);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      // load_val is only meaningful while the load strobe is expected.
      if (!e[11]) begin
        act[10:3] = '0;
        e[10:3]   = '0;
      end
      chk("model_cycle", act, e);
    end
  end

  // ---------------- driver tasks ----------------
  // Raise the selected buttons for one cycle, starting at a negedge.
  task automatic pulse(input logic s, input logic c, input logic l);
    btn_ss = s; btn_clr = c; btn_lap = l;
    @(negedge clk_5MHz);
    btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_5MHz);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    dir_dn = 1'b0; preset = 8'd0;
    wait_neg(3);
    chk("reset_held_state", {14'd0, state}, 16'd0);
    #30 reset = 1'b0;
    wait_neg(5);
    chk("idle_after_reset", {14'd0, state}, {14'd0, ST_IDLE});

    // Count-up start: load 0, RUN, up direction.
    pulse(1, 0, 0); wait_neg(2);
    chk("up_start_load", {15'd0, cnt_load}, 16'd1);
    chk("up_start_val", {8'd0, load_val}, 16'd0);
    chk("up_start_state", {14'd0, state}, {14'd0, ST_RUN});
    chk("up_dir", {15'd0, cnt_up_dn}, 16'd1);
    wait_neg(9);
    chk("no_en_before_div", {15'd0, cnt_en}, 16'd0);
    wait_neg(1);
    chk("first_en_at_div", {14'd0, cnt_en, tick_1hz}, 16'd3);
    wait_neg(10);
    chk("second_en", {14'd0, cnt_en, tick_1hz}, 16'd3);

    // Lap toggles the display hold while enables continue.
    pulse(0, 0, 1); wait_neg(2);
    chk("lap_on", {15'd0, lap_freeze}, 16'd1);
    wait_neg(7);
    chk("en_during_lap", {14'd0, cnt_en, lap_freeze}, 16'd3);
    pulse(0, 0, 1); wait_neg(2);
    chk("lap_off", {15'd0, lap_freeze}, 16'd0);

    // Pause with the prescaler at 6, then resume 4 cycles before the next tick.
    wait_neg(7);
    chk("tick_before_pause", {15'd0, tick_1hz}, 16'd1);
    wait_neg(4);
    pulse(1, 0, 0); wait_neg(2);
    chk("paused", {14'd0, state}, {14'd0, ST_PAUSE});
    pulse(0, 0, 1);
    wait_neg(100);
    chk("lap_ignored_in_pause", {15'd0, lap_freeze}, 16'd0);
    pulse(1, 0, 0); wait_neg(2);
    chk("resumed", {14'd0, state}, {14'd0, ST_RUN});
    wait_neg(3);
    chk("no_tick_resume_3", {15'd0, tick_1hz}, 16'd0);
    wait_neg(1);
    chk("tick_resume_4", {14'd0, cnt_en, tick_1hz}, 16'd3);

    // start/stop and clear in the same cycle: clear wins.
    pulse(0, 0, 1); wait_neg(2);
    chk("lap_before_clr", {15'd0, lap_freeze}, 16'd1);
    pulse(1, 1, 0); wait_neg(2);
    chk("clr_wins", {13'd0, state, lap_freeze}, {13'd0, ST_IDLE, 1'b0});
    chk("clr_load", {7'd0, cnt_load, load_val}, {7'd0, 1'b1, 8'd0});

    // Countdown from 3: three enables, then DONE on the fourth tick.
    dir_dn = 1'b1; preset = 8'd3;
    pulse(1, 0, 0); wait_neg(2);
    chk("dn_start", {5'd0, state, cnt_load, load_val}, {5'd0, ST_RUN, 1'b1, 8'd3});
    chk("dn_dir", {15'd0, cnt_up_dn}, 16'd0);
    dir_dn = 1'b0;
    wait_neg(10);
    chk("dn_tick1", {15'd0, cnt_en}, 16'd1);
    wait_neg(20);
    chk("dn_tick3", {14'd0, cnt_en, cnt_up_dn}, 16'd2);
    wait_neg(10);
    chk("dn_done", {12'd0, state, cnt_en, alarm}, {12'd0, ST_DONE, 1'b0, 1'b1});
    wait_neg(15);
    chk("alarm_holds", {15'd0, alarm}, 16'd1);
    pulse(1, 0, 0); wait_neg(2);
    chk("done_to_idle", {12'd0, state, alarm, cnt_load}, {12'd0, ST_IDLE, 2'b00});

    // Clear in IDLE: load 0 with no state change.
    pulse(0, 1, 0); wait_neg(2);
    chk("idle_clr", {13'd0, state, cnt_load}, {13'd0, ST_IDLE, 1'b1});

    // Reset mid-run with start/stop held through the release.
    pulse(1, 0, 0); wait_neg(7);
    chk("run_before_reset", {14'd0, state}, {14'd0, ST_RUN});
    btn_ss = 1'b1;
    #30 reset = 1'b1;
    #1 chk("async_reset_out", dut_word(), 16'h0000);
    wait_neg(3);
    #30 reset = 1'b0;
    wait_neg(10);
    btn_ss = 1'b0;
    wait_neg(20);
    chk("held_btn_no_press", {14'd0, state}, {14'd0, ST_IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
